// File: rtl/serial_alu_ctrl.sv
// Bit-serial sequencer for a single 1-bit ALU slice: latches operands, feeds the
// slice LSB first with carry feedback, and assembles the WIDTH-bit result.
//
//  state  | meaning
//  -------+------------------------------------------------------------
//  S_IDLE | waiting for start; result/carry_out hold last operation
//  S_RUN  | one operand bit per cycle through the slice, WIDTH cycles
//  S_DONE | one-cycle done pulse; start here re-enters RUN without a gap
module serial_alu_ctrl #(
   parameter int WIDTH = 8
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             start_i,
   input  logic [2:0]       mode_i,
   input  logic [WIDTH-1:0] op_a_i,
   input  logic [WIDTH-1:0] op_b_i,
   input  logic             carry_in_i,
   output logic             busy_o,
   output logic             done_o,
   output logic [WIDTH-1:0] result_o,
   output logic             carry_out_o,
   output logic [2:0]       alu_m_o,
   output logic             alu_a_o,
   output logic             alu_b_o,
   output logic             alu_c_o,
   input  logic             alu_out_i,
   input  logic             alu_next_i
);

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t            state_q;
   logic [CW-1:0]     cnt_q;
   logic [WIDTH-1:0]  a_sh_q;
   logic [WIDTH-1:0]  b_sh_q;
   logic [WIDTH-1:0]  result_q;
   logic [2:0]        m_q;
   logic              cy_q;
   logic              carry_out_q;
   logic              busy_q;
   logic              done_q;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q     <= S_IDLE;
         cnt_q       <= '0;
         a_sh_q      <= '0;
         b_sh_q      <= '0;
         result_q    <= '0;
         m_q         <= 3'b000;
         cy_q        <= 1'b0;
         carry_out_q <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            S_IDLE, S_DONE: begin
               if (start_i) begin
                  a_sh_q      <= op_a_i;
                  b_sh_q      <= op_b_i;
                  m_q         <= mode_i;
                  cy_q        <= carry_in_i;
                  cnt_q       <= '0;
                  result_q    <= '0;
                  carry_out_q <= 1'b0;
                  busy_q      <= 1'b1;
                  state_q     <= S_RUN;
               end else begin
                  state_q <= S_IDLE;
               end
            end
            S_RUN: begin
               // Slice output enters at the MSB so bit 0 lands at result[0] after WIDTH shifts.
               result_q <= {alu_out_i, result_q[WIDTH-1:1]};
               cy_q     <= alu_next_i;
               a_sh_q   <= a_sh_q >> 1;
               b_sh_q   <= b_sh_q >> 1;
               if (cnt_q == CNT_LAST) begin
                  carry_out_q <= alu_next_i;
                  busy_q      <= 1'b0;
                  done_q      <= 1'b1;
                  state_q     <= S_DONE;
               end else begin
                  cnt_q <= cnt_q + CW'(1);
               end
            end
            default: begin
               busy_q  <= 1'b0;
               state_q <= S_IDLE;
            end
         endcase
      end
   end

   // The carry register keeps the last 'next' after RUN, so slice inputs are gated by busy.
   assign alu_a_o     = busy_q & a_sh_q[0];
   assign alu_b_o     = busy_q & b_sh_q[0];
   assign alu_c_o     = busy_q & cy_q;
   assign alu_m_o     = m_q;
   assign busy_o      = busy_q;
   assign done_o      = done_q;
   assign result_o    = result_q;
   assign carry_out_o = carry_out_q;

endmodule
